// File: rtl/gpu.sv
// rtl/gpu.sv - minimal 16-bit in-order shader core, two clocks per instruction
// Fetches from external registered instruction memory; private data RAM and 16x16 register file.
module gpu #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              KEY0,
  input  logic [DATA_W-1:0] data_input,
  output logic [ADDR_W-1:0] input_addr,
  output logic              halted
);

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_WAIT, S_EXEC, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
    OP_LDI, OP_LUI, OP_ADDI, OP_LD, OP_ST, OP_BNZ, OP_JMP, OP_HALT
  } op_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [DATA_W-1:0]  regs [0:15];
  logic [DATA_W-1:0]  dmem [0:DMEM_DEPTH-1];

  op_t                op;
  logic [3:0]         rd, rs, rt;
  logic [7:0]         imm8;
  logic [DATA_W-1:0]  rd_val, rs_val, rt_val, imm_sext;
  logic [ADDR_W-1:0]  br_off;
  logic [DMEM_AW-1:0] mem_addr;

  logic               wr_en;
  logic [DATA_W-1:0]  wr_val;
  logic [ADDR_W-1:0]  next_pc;

  assign input_addr = pc;

  assign op       = op_t'(data_input[15:12]);
  assign rd       = data_input[11:8];
  assign rs       = data_input[7:4];
  assign rt       = data_input[3:0];
  assign imm8     = data_input[7:0];
  assign imm_sext = {{(DATA_W-8){imm8[7]}}, imm8};
  assign br_off   = {{(ADDR_W-8){imm8[7]}}, imm8};

  // r0 is hardwired to zero on every read port
  assign rd_val   = (rd == 4'd0) ? '0 : regs[rd];
  assign rs_val   = (rs == 4'd0) ? '0 : regs[rs];
  assign rt_val   = (rt == 4'd0) ? '0 : regs[rt];
  assign mem_addr = rs_val[DMEM_AW-1:0];

  always_comb begin
    wr_en   = 1'b0;
    wr_val  = '0;
    next_pc = pc + PC_ONE;
    case (op)
      OP_NOP:  ;
      OP_ADD:  begin wr_en = 1'b1; wr_val = rs_val + rt_val; end
      OP_SUB:  begin wr_en = 1'b1; wr_val = rs_val - rt_val; end
      OP_AND:  begin wr_en = 1'b1; wr_val = rs_val & rt_val; end
      OP_OR:   begin wr_en = 1'b1; wr_val = rs_val | rt_val; end
      OP_XOR:  begin wr_en = 1'b1; wr_val = rs_val ^ rt_val; end
      OP_SHL:  begin wr_en = 1'b1; wr_val = rs_val << rt_val[3:0]; end
      OP_SHR:  begin wr_en = 1'b1; wr_val = rs_val >> rt_val[3:0]; end
      OP_LDI:  begin wr_en = 1'b1; wr_val = imm_sext; end
      OP_LUI:  begin wr_en = 1'b1; wr_val = {imm8, rd_val[7:0]}; end
      OP_ADDI: begin wr_en = 1'b1; wr_val = rd_val + imm_sext; end
      OP_LD:   begin wr_en = 1'b1; wr_val = dmem[mem_addr]; end
      OP_ST:   ;
      OP_BNZ:  if (rd_val != '0) next_pc = pc + PC_ONE + br_off;
      OP_JMP:  next_pc = {pc[ADDR_W-1:12], data_input[11:0]};
      OP_HALT: next_pc = pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge KEY0) begin
    if (KEY0) begin
      state  <= S_WAIT;
      pc     <= '0;
      halted <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_WAIT: state <= S_EXEC;
        S_EXEC: begin
          if (wr_en && rd != 4'd0) regs[rd] <= wr_val;
          pc <= next_pc;
          if (op == OP_HALT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_WAIT;
      endcase
    end
  end

  // Data RAM keeps its contents across reset; a reset edge must still suppress a pending store
  always_ff @(posedge clk) begin
    if (!KEY0 && state == S_EXEC && op == OP_ST) dmem[mem_addr] <= rd_val;
  end

endmodule

// File: tb/tb_gpu.sv
// tb/tb_gpu.sv - directed-program bench for gpu
// Fetch order is captured as the sequence of distinct input_addr values.
module tb_gpu;

  logic        clk = 1'b0;
  logic        KEY0 = 1'b1;
  logic [15:0] data_input = '0;
  logic [19:0] input_addr;
  logic        halted;

  logic [15:0] imem [0:1023];
  logic [19:0] trace [$];
  logic [19:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  gpu dut (
    .clk        (clk),
    .KEY0       (KEY0),
    .data_input (data_input),
    .input_addr (input_addr),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) data_input <= imem[input_addr[9:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    KEY0 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_until_halt(input int budget);
    trace.delete();
    trace.push_back(input_addr);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (input_addr != trace[trace.size()-1]) trace.push_back(input_addr);
      if (halted) break;
    end
  endtask

  task automatic release_and_run(input int budget);
    @(negedge clk);
    KEY0 = 1'b0;
    run_until_halt(budget);
  endtask

  task automatic check_trace(input string tag);
    check({tag, " len"}, trace.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), (i < trace.size()) ? trace[i] : 20'hFFFFF, exp_q[i]);
    check({tag, " halted"}, halted, 1'b1);
  endtask

  initial begin
    clear_imem();
    repeat (3) @(negedge clk);
    check("reset addr", input_addr, 20'h0);
    check("reset halted", halted, 1'b0);

    // NOP sequencing: input_addr advances once per two clocks
    KEY0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("seq k%0d", k), input_addr, k / 2);
    end

    // Countdown loop
    hold_reset();
    clear_imem();
    imem[0] = 16'h8103; imem[1] = 16'hA1FF; imem[2] = 16'hD1FE; imem[3] = 16'hF000;
    release_and_run(200);
    exp_q = '{20'd0, 20'd1, 20'd2, 20'd1, 20'd2, 20'd1, 20'd2, 20'd3};
    check_trace("loop");
    repeat (4) @(negedge clk);
    check("loop hold addr", input_addr, 20'd3);
    check("loop hold halted", halted, 1'b1);

    // Jump
    hold_reset();
    clear_imem();
    imem[0] = 16'hE120; imem[10'h120] = 16'hF000;
    release_and_run(100);
    exp_q = '{20'h0, 20'h120};
    check_trace("jmp");

    // Store then load back
    hold_reset();
    clear_imem();
    imem[0] = 16'h8255; imem[1] = 16'h8307; imem[2] = 16'hC230; imem[3] = 16'hB430;
    imem[4] = 16'h2542; imem[5] = 16'hD503; imem[6] = 16'hF000; imem[9] = 16'hF000;
    release_and_run(100);
    exp_q = '{20'd0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6};
    check_trace("mem");

    // Preload dmem[7]=0x12 for the variant; RAM survives reset
    hold_reset();
    clear_imem();
    imem[0] = 16'h8612; imem[1] = 16'h8307; imem[2] = 16'hC630; imem[3] = 16'hF000;
    release_and_run(100);
    check("preload halted", halted, 1'b1);

    hold_reset();
    clear_imem();
    imem[0] = 16'h8255; imem[1] = 16'h8307; imem[2] = 16'h0000; imem[3] = 16'hB430;
    imem[4] = 16'h2542; imem[5] = 16'hD503; imem[6] = 16'hF000; imem[9] = 16'hF000;
    release_and_run(100);
    exp_q = '{20'd0, 20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd9};
    check_trace("mem var");

    // r0 stays zero
    hold_reset();
    clear_imem();
    imem[0] = 16'h8005; imem[1] = 16'hD004; imem[2] = 16'hF000; imem[6] = 16'hF000;
    release_and_run(100);
    exp_q = '{20'd0, 20'd1, 20'd2};
    check_trace("r0");

    // Reset pulse while halted
    hold_reset();
    clear_imem();
    imem[5] = 16'hF000;
    release_and_run(100);
    check("halt5 addr", input_addr, 20'd5);
    check("halt5 halted", halted, 1'b1);
    @(negedge clk);
    KEY0 = 1'b1;
    #1;
    check("pulse addr", input_addr, 20'd0);
    check("pulse halted", halted, 1'b0);
    @(negedge clk);
    KEY0 = 1'b0;
    repeat (2) @(negedge clk);
    check("restart addr", input_addr, 20'd1);
    check("restart halted", halted, 1'b0);
    run_until_halt(100);
    check("rehalt addr", input_addr, 20'd5);
    check("rehalt halted", halted, 1'b1);

    // Reset during EXEC of a store: clear dmem[9], attempt 0x55 store, then read back
    hold_reset();
    clear_imem();
    imem[0] = 16'h8309; imem[1] = 16'hC030; imem[2] = 16'hF000;
    release_and_run(100);
    check("clr halted", halted, 1'b1);

    hold_reset();
    clear_imem();
    imem[0] = 16'h8255; imem[1] = 16'h8309; imem[2] = 16'hC230; imem[3] = 16'hF000;
    @(negedge clk);
    KEY0 = 1'b0;
    repeat (5) @(negedge clk);
    check("st exec addr", input_addr, 20'd2);
    KEY0 = 1'b1;
    @(negedge clk);
    clear_imem();
    imem[0] = 16'h8309; imem[1] = 16'hB430; imem[2] = 16'hD403; imem[3] = 16'hF000;
    imem[6] = 16'hF000;
    release_and_run(100);
    exp_q = '{20'd0, 20'd1, 20'd2, 20'd3};
    check_trace("abort st");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu.md
Name: gpu

Overview:
- Minimal 16-bit in-order shader core; top of the fpga_version design.
- Fetches 16-bit instructions from an external synchronous instruction memory through a 20-bit address and executes them against a 16x16 register file and a private data RAM.
- Runs from address 0 after reset until a HALT instruction; a new reset restarts it.

Parameters:
- ADDR_W, 20, instruction address / PC width.
- DATA_W, 16, instruction and data word width.
- DMEM_DEPTH, 256, internal data RAM words (8-bit address).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- KEY0  input  1  asynchronous active-high reset.
- data_input  input  16  instruction word from external memory; valid one clock after input_addr is sampled by memory (registered read).
- input_addr  output  20  instruction fetch address; equals the PC, driven from a register.
- halted  output  1  high while stopped on HALT; may be left unconnected.

Behaviour:
- Reset (KEY0=1, async): pc=0, input_addr=0, r1..r15=0, halted=0, state=WAIT. Data RAM is not cleared. Reset mid-instruction aborts it with no register or RAM write.
- FSM, 2 cycles per instruction:
  - WAIT -> EXEC. Memory captures mem[pc] at this edge.
  - EXEC: on the edge, sample data_input as the instruction, execute, write back, update pc, then -> WAIT.
  - pc changes only in EXEC, so input_addr is stable for 2 cycles per instruction.
- Encoding: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0], imm8=[7:0]. r0 reads 0; writes to r0 are ignored. Default next pc = pc+1, modulo 2^20 (0xFFFFF wraps to 0).
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs+rt.
  - 2 SUB rd=rs-rt.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL rd=rs<<rt[3:0].
  - 7 SHR rd=rs>>rt[3:0] (logical).
  - 8 LDI rd=sext(imm8).
  - 9 LUI rd={imm8, rd[7:0]}.
  - A ADDI rd=rd+sext(imm8).
  - B LD rd=dmem[rs[7:0]], read combinationally within EXEC.
  - C ST dmem[rs[7:0]]=rd.
  - D BNZ: if rd!=0 then pc=pc+1+sext(imm8), else pc+1.
  - E JMP pc={pc[19:12], instr[11:0]}.
  - F HALT: pc unchanged, halted=1, FSM parks in HALT state until reset.
- Arithmetic is 16-bit modulo 2^16; no flags or carry.
- Branch target arithmetic is 20-bit modulo 2^20.
- LD immediately after ST to the same address returns the stored value (the write completes in the earlier EXEC).
- Unknown or X data_input is not checked; every 4-bit opcode is defined, so there is no illegal-instruction trap.

Test Plan:
- Reset/sequencing:
  - Hold KEY0=1 -> input_addr=0, halted=0.
  - Release with memory full of 0x0000 (NOP) -> input_addr steps 0,0,1,1,2,2,... (one increment per 2 clocks).
- Loop:
  - Program: addr0 0x8103 (LDI r1,3), addr1 0xA1FF (ADDI r1,-1), addr2 0xD1FE (BNZ r1,-2), addr3 0xF000.
  - Required input_addr instruction order: 0,1,2,1,2,1,2,3, then holds at 3 with halted=1.
- Jump: addr0 0xE120 -> next fetched address 0x120; addr 0x120 holds 0xF000 -> halted=1 with input_addr=0x120.
- Memory round trip:
  - Program: 0x8255 (LDI r2,0x55), 0x8307 (LDI r3,7), 0xC230 (ST r2,[r3]), 0xB430 (LD r4,[r3]), 0x2542 (SUB r5,r4,r2), 0xD503 (BNZ r5,+3), 0xF000.
  - Required: branch not taken, halts at addr 6.
  - Variant: replace the ST with NOP and preload dmem[7]=0x12 -> branch taken, fetch 9.
- r0 zero: 0x8005 (LDI r0,5), 0xD004 (BNZ r0,+4), 0xF000 -> halts at addr 2, not 6.
- Reset while halted and mid-instruction:
  - After HALT at addr 5, pulse KEY0 one cycle -> input_addr=0, halted=0, execution restarts.
  - Assert KEY0 during EXEC of an ST -> the targeted dmem word is unchanged.
